s_mem_arbiter: RTL and testbench

- Arbitrates the single-port S memory (256x8, synchronous read) between the init, shuffle and decrypt FSMs, and returns read data to the requester that issued the read.
- Sits between the three FSMs and s_memory, replacing the combinational memory_handler mux.
- Adds request/grant/done handshakes with locked ownership, so each phase owns the memory exclusively until it releases it.
- Adds per-requester read-valid tagging that accounts for the memory read latency.

---
 rtl/s_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_s_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// Arbiter for the single-port S memory shared by the init, shuffle and decrypt FSMs.
// Locked ownership via req/grant/done, plus per-requester tagging of read data.
module s_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1   // legal range 1..3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          done,
  input  logic [2:0]          acc,
  input  logic [2:0]          wren_in,
  input  logic [3*ADDR_W-1:0] addr_in,
  input  logic [3*DATA_W-1:0] data_in,
  output logic [2:0]          grant,
  output logic [1:0]          owner,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   data,
  output logic                wren,
  input  logic [DATA_W-1:0]   q,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          rvalid
);

  // Handshake: a requester holds req until it sees its grant bit, then owns the
  // memory for as many cycles as it likes; a one-cycle done from the owner
  // releases it. Only the owner's acc/wren_in/done are ever looked at.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [1:0]                owner_q, owner_d;
  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         data_q;
  logic [READ_LATENCY-1:0]   pv_q, pv_d;
  logic [2*READ_LATENCY-1:0] ptag_q, ptag_d;

  logic              own_acc, own_wren, own_done;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              in_grant, rd_push, pipe_empty, tail_v;
  logic [1:0]        tail_tag;

  always_comb begin
    own_acc  = 1'b0;
    own_wren = 1'b0;
    own_done = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int k = 0; k < 3; k++) begin
      if (owner_q == 2'(k)) begin
        own_acc  = acc[k];
        own_wren = wren_in[k];
        own_done = done[k];
        own_addr = addr_in[k*ADDR_W +: ADDR_W];
        own_data = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign in_grant = (state_q == ST_GRANT);
  assign rd_push  = in_grant & own_acc & ~own_wren;

  // Each slot carries a valid bit and the issuing requester; writes push empty slots.
  if (READ_LATENCY > 1) begin : g_shift
    assign pv_d   = {pv_q[READ_LATENCY-2:0], rd_push};
    assign ptag_d = {ptag_q[2*READ_LATENCY-3:0], owner_q};
  end else begin : g_single
    assign pv_d   = rd_push;
    assign ptag_d = owner_q;
  end

  assign tail_v     = pv_q[READ_LATENCY-1];
  assign tail_tag   = ptag_q[2*READ_LATENCY-1 -: 2];
  assign pipe_empty = ~|pv_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          if (req[0])      owner_d = 2'd0;
          else if (req[1]) owner_d = 2'd1;
          else             owner_d = 2'd2;
        end
      end
      ST_GRANT: begin
        if (own_done) begin
          state_d = ST_DRAIN;
          owner_d = OWN_NONE;
        end
      end
      // Stay until every tagged read has been delivered to its requester.
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      pv_q    <= '0;
      ptag_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pv_q    <= pv_d;
      ptag_q  <= ptag_d;
      if (in_grant) begin
        addr_q <= own_addr;
        data_q <= own_data;
      end
    end
  end

  assign grant   = in_grant ? (3'b001 << owner_q) : 3'b000;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);
  assign address = in_grant ? own_addr : addr_q;
  assign data    = in_grant ? own_data : data_q;
  assign wren    = in_grant & own_acc & own_wren;
  assign rdata   = q;
  assign rvalid  = tail_v ? (3'b001 << tail_tag) : 3'b000;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: two instances (read latency 1 and 3) share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_s_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    req, done, acc, wren_in;
  logic [3*AW-1:0] addr_in;
  logic [3*DW-1:0] data_in;
  logic [DW-1:0] q;

  logic [2:0]    grant_o[2];
  logic [1:0]    owner_o[2];
  logic          busy_o[2];
  logic [AW-1:0] address_o[2];
  logic [DW-1:0] data_o[2];
  logic          wren_o[2];
  logic [DW-1:0] rdata_o[2];
  logic [2:0]    rvalid_o[2];

  s_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut_rl1 (
    .clk(clk), .reset(reset), .req(req), .done(done), .acc(acc), .wren_in(wren_in),
    .addr_in(addr_in), .data_in(data_in), .grant(grant_o[0]), .owner(owner_o[0]),
    .busy(busy_o[0]), .address(address_o[0]), .data(data_o[0]), .wren(wren_o[0]),
    .q(q), .rdata(rdata_o[0]), .rvalid(rvalid_o[0])
  );

  s_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) u_dut_rl3 (
    .clk(clk), .reset(reset), .req(req), .done(done), .acc(acc), .wren_in(wren_in),
    .addr_in(addr_in), .data_in(data_in), .grant(grant_o[1]), .owner(owner_o[1]),
    .busy(busy_o[1]), .address(address_o[1]), .data(data_o[1]), .wren(wren_o[1]),
    .q(q), .rdata(rdata_o[1]), .rvalid(rvalid_o[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 8;

  // phase: 0 idle, 1 owned, 2 draining. A read issued in cycle c is logged at
  // slot c%8 and is due on rvalid in cycle c+latency.
  int            m_ph[2];
  int            m_own[2];
  logic [AW-1:0] m_la[2];
  logic [DW-1:0] m_ld[2];
  logic          m_iv[2][8];
  logic [1:0]    m_io[2][8];

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int k);
    return addr_in[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int k);
    return data_in[k*DW +: DW];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int            o, idx;
      logic [2:0]    eg, erv;
      logic [1:0]    eo;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ew;
      o = m_own[i];
      if (m_ph[i] == 1) begin
        eg = 3'(1 << o);
        eo = 2'(o);
        ea = addr_of(o);
        ed = data_of(o);
        ew = acc[o] & wren_in[o];
      end else begin
        eg = 3'b000;
        eo = 2'd3;
        ea = m_la[i];
        ed = m_ld[i];
        ew = 1'b0;
      end
      idx = (cyc - rl_of(i)) & 7;
      erv = m_iv[i][idx] ? 3'(1 << m_io[i][idx]) : 3'b000;
      check_eq($sformatf("grant_rl%0d", rl_of(i)),   32'(grant_o[i]),   32'(eg));
      check_eq($sformatf("owner_rl%0d", rl_of(i)),   32'(owner_o[i]),   32'(eo));
      check_eq($sformatf("busy_rl%0d", rl_of(i)),    32'(busy_o[i]),    32'(m_ph[i] != 0));
      check_eq($sformatf("address_rl%0d", rl_of(i)), 32'(address_o[i]), 32'(ea));
      check_eq($sformatf("data_rl%0d", rl_of(i)),    32'(data_o[i]),    32'(ed));
      check_eq($sformatf("wren_rl%0d", rl_of(i)),    32'(wren_o[i]),    32'(ew));
      check_eq($sformatf("rvalid_rl%0d", rl_of(i)),  32'(rvalid_o[i]),  32'(erv));
      check_eq($sformatf("rdata_rl%0d", rl_of(i)),   32'(rdata_o[i]),   32'(q));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int   c, o;
      logic rd, infl;
      c = cyc;
      o = m_own[i];
      if (reset) begin
        m_ph[i]  = 0;
        m_own[i] = 3;
        m_la[i]  = '0;
        m_ld[i]  = '0;
        for (int k = 0; k < 8; k++) m_iv[i][k] = 1'b0;
      end else begin
        rd = 1'b0;
        if (m_ph[i] == 1) rd = acc[o] & ~wren_in[o];
        m_iv[i][c & 7] = rd;
        m_io[i][c & 7] = 2'(o);
        if (m_ph[i] == 0) begin
          if (req != 3'b000) begin
            m_ph[i]  = 1;
            m_own[i] = req[0] ? 0 : (req[1] ? 1 : 2);
          end
        end else if (m_ph[i] == 1) begin
          m_la[i] = addr_of(o);
          m_ld[i] = data_of(o);
          if (done[o]) begin
            m_ph[i]  = 2;
            m_own[i] = 3;
          end
        end else begin
          infl = 1'b0;
          for (int k = 1; k <= rl_of(i); k++) if (m_iv[i][(c - k) & 7]) infl = 1'b1;
          if (!infl) m_ph[i] = 0;
        end
      end
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 3'b000; done = 3'b000; acc = 3'b000; wren_in = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int inst, input int idx);
    int n;
    n = 0;
    while (grant_o[inst] !== 3'(1 << idx) && n < 40) begin
      step();
      n++;
    end
    check_eq($sformatf("wait_grant%0d_inst%0d", idx, inst), 32'(grant_o[inst]), 32'(1 << idx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_own[i] = 3; m_la[i] = '0; m_ld[i] = '0;
      for (int k = 0; k < 8; k++) begin
        m_iv[i][k] = 1'b0;
        m_io[i][k] = 2'd0;
      end
    end
    reset = 1'b1; req = 3'b000; done = 3'b000; acc = 3'b000; wren_in = 3'b000;
    addr_in = '0; data_in = '0; q = '0;
    @(posedge clk);
    #1;
    do_reset();

    // reset values
    #1;
    check_eq("rst_grant", 32'(grant_o[0]), 32'd0);
    check_eq("rst_owner", 32'(owner_o[0]), 32'd3);
    check_eq("rst_busy",  32'(busy_o[0]),  32'd0);
    check_eq("rst_addr",  32'(address_o[0]), 32'd0);

    // single owner write, then release
    req = 3'b001;
    step();
    check_eq("s1_grant", 32'(grant_o[0]), 32'b001);
    check_eq("s1_owner", 32'(owner_o[0]), 32'd0);
    acc = 3'b001; wren_in = 3'b001; addr_in = 24'h000005; data_in = 24'h000005;
    #1;
    check_eq("s1_wren", 32'(wren_o[0]), 32'd1);
    check_eq("s1_addr", 32'(address_o[0]), 32'h05);
    step();
    acc = 3'b000; wren_in = 3'b000; done = 3'b001; req = 3'b000;
    step();
    done = 3'b000;
    check_eq("s1_drain_busy",  32'(busy_o[0]),  32'd1);
    check_eq("s1_drain_grant", 32'(grant_o[0]), 32'd0);
    step();
    check_eq("s1_idle_busy",  32'(busy_o[0]),  32'd0);
    check_eq("s1_idle_owner", 32'(owner_o[0]), 32'd3);
    step();

    // simultaneous requests, no preemption
    req = 3'b110;
    step();
    check_eq("s2_first", 32'(grant_o[0]), 32'b010);
    req = 3'b111;
    step();
    step();
    check_eq("s2_no_preempt", 32'(grant_o[0]), 32'b010);
    req = 3'b101; done = 3'b010;
    step();
    done = 3'b000;
    wait_grant(0, 0);
    req = 3'b100; done = 3'b001;
    step();
    done = 3'b000;
    wait_grant(0, 2);

    // back-to-back reads, latency 1
    acc = 3'b100; wren_in = 3'b000; addr_in = 24'h100000;
    step();
    addr_in = 24'h110000; q = 8'hA0;
    #1;
    check_eq("s3_rv0", 32'(rvalid_o[0]), 32'b100);
    check_eq("s3_rd0", 32'(rdata_o[0]), 32'hA0);
    step();
    addr_in = 24'h120000; q = 8'hA1;
    #1;
    check_eq("s3_rv1", 32'(rvalid_o[0]), 32'b100);
    check_eq("s3_rd1", 32'(rdata_o[0]), 32'hA1);
    step();
    acc = 3'b000; q = 8'hA2;
    #1;
    check_eq("s3_rv2", 32'(rvalid_o[0]), 32'b100);
    check_eq("s3_rd2", 32'(rdata_o[0]), 32'hA2);
    step();
    q = 8'h5A;
    #1;
    check_eq("s3_rv_end", 32'(rvalid_o[0]), 32'd0);
    done = 3'b100; req = 3'b000;
    step();
    done = 3'b000;
    for (int k = 0; k < 6; k++) step();

    // non-owner write attempt
    req = 3'b010;
    wait_grant(0, 1);
    addr_in = 24'h773C55; data_in = 24'hEEDDCC;
    acc = 3'b101; wren_in = 3'b101;
    #1;
    check_eq("s4_wren", 32'(wren_o[0]), 32'd0);
    check_eq("s4_addr", 32'(address_o[0]), 32'h3C);
    step();
    acc = 3'b000; wren_in = 3'b000; done = 3'b010; req = 3'b000;
    step();
    done = 3'b000;
    for (int k = 0; k < 6; k++) step();

    // read with done in the same cycle, latency 3
    do_reset();
    req = 3'b001;
    wait_grant(1, 0);
    acc = 3'b001; wren_in = 3'b000; done = 3'b001; addr_in = 24'h000020;
    step();
    acc = 3'b000; done = 3'b000; req = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_eq($sformatf("s5_rv_k%0d", k),    32'(rvalid_o[1]), (k == 3) ? 32'b001 : 32'd0);
      check_eq($sformatf("s5_grant_k%0d", k), 32'(grant_o[1]),  (k == 6) ? 32'b010 : 32'd0);
      step();
    end
    done = 3'b010; req = 3'b000;
    step();
    done = 3'b000;
    for (int k = 0; k < 6; k++) step();

    // reset with a read in flight
    do_reset();
    req = 3'b001;
    wait_grant(1, 0);
    acc = 3'b001; wren_in = 3'b000;
    step();
    reset = 1'b1; acc = 3'b000; req = 3'b000;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check_eq($sformatf("s6_rv_k%0d", k),    32'(rvalid_o[1]), 32'd0);
      check_eq($sformatf("s6_grant_k%0d", k), 32'(grant_o[1]),  32'd0);
      check_eq($sformatf("s6_owner_k%0d", k), 32'(owner_o[1]),  32'd3);
      step();
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req     = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) done[k] = ($urandom_range(0, 5) == 0);
      acc     = 3'($urandom_range(0, 7));
      wren_in = 3'($urandom_range(0, 7));
      addr_in = 24'($urandom());
      data_in = 24'($urandom());
      q       = 8'($urandom_range(0, 255));
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
